effect_gain: RTL

EFFECT_GAIN -- requirements
Module: effect_gain

---
 rtl/effect_gain_pkg.sv | 9 +
 rtl/gain_ramp.sv | 34 +++
 rtl/effect_gain.sv | 38 +++
 3 files changed

// File: rtl/effect_gain_pkg.sv
// effect_gain_pkg: shared gain limits, shift and ramp state type
package effect_gain_pkg;
  localparam logic [3:0] MAX_LEVEL = 4'd8;
  localparam int GAIN_SHIFT = 3;
  typedef enum logic [1:0] {HOLD, UP, DOWN} ramp_state_t;
  function automatic logic [3:0] clamp_level(input logic [3:0] l);
    return l > MAX_LEVEL ? MAX_LEVEL : l;
  endfunction
endpackage

// File: rtl/gain_ramp.sv
// gain_ramp: step timer plus ramp FSM moving gain one level per tick toward the clamped target
module gain_ramp
  import effect_gain_pkg::*;
#(
  parameter int STEP_DIV = 40000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] target_in,
  output logic [3:0] gain,
  output logic       ramping
);
  localparam int TW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  logic [TW-1:0] cnt;
  logic [3:0] target, gain_nxt;
  logic tick;
  ramp_state_t state;
  assign tick = cnt == TW'(STEP_DIV - 1);
  always_comb begin
    state = gain < target ? UP : gain > target ? DOWN : HOLD;
    gain_nxt = !tick ? gain : state == UP ? gain + 4'd1 : state == DOWN ? gain - 4'd1 : gain;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      target <= '0;
      gain <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      target <= clamp_level(target_in);
      gain <= gain_nxt;
    end
  assign ramping = state != HOLD;
endmodule

// File: rtl/effect_gain.sv
// effect_gain: distance-driven ramped gain applied to a valid/ready audio sample stream
module effect_gain
  import effect_gain_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int STEP_DIV = 40000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          intensity,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic [3:0]          gain,
  output logic                ramping
);
  logic signed [SAMPLE_W+4:0] prod;
  gain_ramp #(.STEP_DIV(STEP_DIV)) u_ramp (
    .clk(clk),
    .reset(reset),
    .target_in(intensity),
    .gain(gain),
    .ramping(ramping)
  );
  assign prod = (SAMPLE_W+5)'($signed(in_sample)) * (SAMPLE_W+5)'($signed({1'b0, gain}));
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_sample <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_sample <= SAMPLE_W'(prod >>> GAIN_SHIFT);
    end
endmodule
